// File: rtl/uart_alu_ctrl_pkg.sv
// Shared constants for the UART/ALU command sequencer.
// State encodings and default widths live here.
package uart_alu_ctrl_pkg;

    localparam int DEF_NB_DATA       = 8;
    localparam int DEF_NB_OP         = 6;
    localparam int DEF_TIMEOUT_TICKS = 640;

    localparam logic [2:0] WAIT_A   = 3'd0;
    localparam logic [2:0] WAIT_B   = 3'd1;
    localparam logic [2:0] WAIT_OP  = 3'd2;
    localparam logic [2:0] CAPTURE  = 3'd3;
    localparam logic [2:0] START_TX = 3'd4;
    localparam logic [2:0] WAIT_TX  = 3'd5;

endpackage

// File: rtl/uart_alu_ctrl_timeout_cnt.sv
// Inter-byte timeout counter: clear, enable and a one-cycle expiry strobe.
// Only instantiated when UART_ALU_CTRL_TIMEOUT_EN is defined.
module uart_timeout_cnt
    import uart_alu_ctrl_pkg::*;
#(
    parameter int TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int NB_CNT = $clog2(TICKS + 1);

    logic [NB_CNT-1:0] r_cnt;

    // Clear wins over expiry so an accepted byte never times out.
    assign o_expire = i_en && !i_clr && (r_cnt == NB_CNT'(TICKS - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer: rx A, B, opcode -> ALU -> one tx request -> wait tx done.
// Optional inter-byte timeout under `UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int NB_DATA       = DEF_NB_DATA,
    parameter int NB_OP         = DEF_NB_OP,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_drop_tick
);

    logic [2:0]         r_state;
    logic [2:0]         w_state_n;
    logic [NB_DATA-1:0] w_alu_a_n;
    logic [NB_DATA-1:0] w_alu_b_n;
    logic [NB_OP-1:0]   w_alu_op_n;
    logic [NB_DATA-1:0] w_tx_data_n;
    logic               w_tx_start_n;
    logic               w_drop_n;
    logic               w_rx_accept;
    logic               w_in_wait_bop;
    logic               w_expire;
    logic               w_unused;

    assign w_in_wait_bop = (r_state == WAIT_B) || (r_state == WAIT_OP);
    assign w_rx_accept   = i_rx_done_tick &&
                           (w_in_wait_bop || (r_state == WAIT_A));
    assign w_unused      = ^{i_s_tick, i_rx_data};

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    uart_timeout_cnt #(
        .TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_rx_accept || !w_in_wait_bop),
        .i_en    (i_s_tick && w_in_wait_bop),
        .o_expire(w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= WAIT_A;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_drop_tick <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            o_alu_a     <= w_alu_a_n;
            o_alu_b     <= w_alu_b_n;
            o_alu_op    <= w_alu_op_n;
            o_tx_data   <= w_tx_data_n;
            o_tx_start  <= w_tx_start_n;
            o_drop_tick <= w_drop_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            WAIT_A:   if (i_rx_done_tick) w_state_n = WAIT_B;
            WAIT_B: begin
                if (i_rx_done_tick) w_state_n = WAIT_OP;
                else if (w_expire)  w_state_n = WAIT_A;
            end
            WAIT_OP: begin
                if (i_rx_done_tick) w_state_n = CAPTURE;
                else if (w_expire)  w_state_n = WAIT_A;
            end
            CAPTURE:  w_state_n = START_TX;
            START_TX: w_state_n = WAIT_TX;
            WAIT_TX:  if (i_tx_done_tick) w_state_n = WAIT_A;
            default:  w_state_n = WAIT_A;
        endcase
    end

    always_comb begin
        w_alu_a_n    = o_alu_a;
        w_alu_b_n    = o_alu_b;
        w_alu_op_n   = o_alu_op;
        w_tx_data_n  = o_tx_data;
        w_tx_start_n = 1'b0;
        w_drop_n     = w_expire;
        case (r_state)
            WAIT_A:  if (i_rx_done_tick) w_alu_a_n = i_rx_data;
            WAIT_B:  if (i_rx_done_tick) w_alu_b_n = i_rx_data;
            WAIT_OP: if (i_rx_done_tick) w_alu_op_n = i_rx_data[NB_OP-1:0];
            CAPTURE: begin
                w_tx_data_n  = i_alu_result;
                w_tx_start_n = 1'b1;
                w_drop_n     = i_rx_done_tick;
            end
            START_TX, WAIT_TX: w_drop_n = i_rx_done_tick;
            default: ;
        endcase
    end

    assign o_busy = (r_state != WAIT_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl with an ADD/SUB ALU model.
// Timeout section follows `UART_ALU_CTRL_TIMEOUT_EN.
module tb_uart_alu_ctrl;

    localparam int TO_TICKS = 640;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_s_tick = 1'b0;
    logic       i_rx_done_tick = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic [7:0] i_alu_result;
    logic       i_tx_done_tick = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_drop_tick;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    uart_alu_ctrl #(
        .NB_DATA(8),
        .NB_OP(6),
        .TIMEOUT_TICKS(TO_TICKS)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_s_tick      (i_s_tick),
        .i_rx_done_tick(i_rx_done_tick),
        .i_rx_data     (i_rx_data),
        .i_alu_result  (i_alu_result),
        .i_tx_done_tick(i_tx_done_tick),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_op      (o_alu_op),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_busy        (o_busy),
        .o_drop_tick   (o_drop_tick)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    // ALU model: 0x20 ADD, 0x22 SUB, anything else 0
    assign i_alu_result = (o_alu_op == 6'h20) ? o_alu_a + o_alu_b :
                          (o_alu_op == 6'h22) ? o_alu_a - o_alu_b : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge i_clk) begin
        if (o_tx_start) begin
            if (sb.size() == 0) begin
                chk("tx_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tx_data", o_tx_data, e.d);
                chk("tx_latency", cyc, e.cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last,
                             input logic [7:0] exp);
        @(posedge i_clk) #1;
        i_rx_done_tick = 1'b1;
        i_rx_data      = b;
        if (last) sb.push_back('{d: exp, cyc: cyc + 2});
        @(posedge i_clk) #1;
        i_rx_done_tick = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
        send_byte(a, 0, 0);
        send_byte(b, 0, 0);
        send_byte(op, 1, exp);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (o_tx_start) break;
        end
        chk("tx_start_seen", o_tx_start, 1);
        chk("alu_a", o_alu_a, a);
        chk("alu_b", o_alu_b, b);
        chk("alu_op", o_alu_op, op & 8'h3F);
    endtask

    task automatic tx_done_pulse();
        @(posedge i_clk) #1;
        i_tx_done_tick = 1'b1;
        @(posedge i_clk) #1;
        i_tx_done_tick = 1'b0;
    endtask

    task automatic finish_tx();
        @(negedge i_clk);
        chk("tx_start_width", o_tx_start, 0);
        chk("busy_wait_tx", o_busy, 1);
        repeat (2) @(posedge i_clk);
        tx_done_pulse();
        @(negedge i_clk);
        chk("busy_after_done", o_busy, 0);
    endtask

    task automatic s_tick_pulse();
        @(posedge i_clk) #1;
        i_s_tick = 1'b1;
        @(posedge i_clk) #1;
        i_s_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge i_clk) #1;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rst_alu_a", o_alu_a, 0);
        chk("rst_alu_b", o_alu_b, 0);
        chk("rst_alu_op", o_alu_op, 0);
        chk("rst_tx", {o_tx_start, o_tx_data}, 0);
        chk("rst_busy_drop", {o_busy, o_drop_tick}, 0);
        #1 i_reset = 1'b0;

        run_cmd(8'h05, 8'h03, 8'h20, 8'h08);
        finish_tx();

        run_cmd(8'h09, 8'h04, 8'hE2, 8'h05);
        finish_tx();

        run_cmd(8'h30, 8'h10, 8'h20, 8'h40);
        @(negedge i_clk);
        send_byte(8'hAA, 0, 0);
        @(negedge i_clk);
        chk("drop_wait_tx", o_drop_tick, 1);
        chk("drop_keeps_a", o_alu_a, 8'h30);
        @(negedge i_clk);
        chk("drop_one_cycle", o_drop_tick, 0);
        chk("drop_still_busy", o_busy, 1);
        tx_done_pulse();
        @(negedge i_clk);
        chk("busy_after_drop", o_busy, 0);
        run_cmd(8'h01, 8'h01, 8'h20, 8'h02);
        finish_tx();

        run_cmd(8'h44, 8'h11, 8'h20, 8'h55);
        @(negedge i_clk);
        @(posedge i_clk) #1;
        i_tx_done_tick = 1'b1;
        i_rx_done_tick = 1'b1;
        i_rx_data      = 8'h77;
        @(posedge i_clk) #1;
        i_tx_done_tick = 1'b0;
        i_rx_done_tick = 1'b0;
        @(negedge i_clk);
        chk("simul_busy", o_busy, 0);
        chk("simul_drop", o_drop_tick, 1);
        chk("simul_alu_a", o_alu_a, 8'h44);

        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        #1 i_reset = 1'b1;
        #1;
        chk("rst_mid_ab", {o_alu_a, o_alu_b}, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_tx", {o_tx_start, o_tx_data, o_alu_op}, 0);
        @(posedge i_clk) #1 i_reset = 1'b0;
        run_cmd(8'h10, 8'h02, 8'h20, 8'h12);
        #1 i_reset = 1'b1;
        #1;
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_busy", o_busy, 0);
        @(posedge i_clk) #1 i_reset = 1'b0;
        run_cmd(8'h10, 8'h02, 8'h20, 8'h12);
        finish_tx();

        send_byte(8'h05, 0, 0);
        repeat (TO_TICKS - 1) s_tick_pulse();
        @(negedge i_clk);
        chk("to_before_busy", o_busy, 1);
        s_tick_pulse();
        @(negedge i_clk);
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        chk("to_drop", o_drop_tick, 1);
        chk("to_busy", o_busy, 0);
        chk("to_keep_a", o_alu_a, 8'h05);
        @(negedge i_clk);
        chk("to_drop_once", o_drop_tick, 0);
`else
        chk("no_to_busy", o_busy, 1);
        chk("no_to_drop", o_drop_tick, 0);
`endif
        do_reset();
        run_cmd(8'hF0, 8'h0F, 8'h20, 8'hFF);
        finish_tx();

        repeat (4) @(negedge i_clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
